// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction-fetch slice (state codes, entry layout).
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] HALT_WORD    = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP_WORD     = 32'h0000_0000;

  localparam logic [0:0] ST_FETCH = 1'b0;
  localparam logic [0:0] ST_HALT  = 1'b1;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } fetch_entry_t;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit (master) and imem (slave).
interface if_fetch_unit_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_fifo.sv
// Fetch buffer: BUF_DEPTH x {addr,data} FIFO with flush; push+pop when full is allowed.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int BUF_DEPTH = 2,
  localparam int CW        = $clog2(BUF_DEPTH + 1),
  localparam int PW        = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1
) (
  input  logic          CLOCK,
  input  logic          RESET,
  input  logic          flush,
  input  logic          push,
  input  fetch_entry_t  din,
  input  logic          pop,
  output fetch_entry_t  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem [BUF_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          wr_en;
  logic          rd_en;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty = (count == '0);
  assign full  = (count == CW'(BUF_DEPTH));
  assign wr_en = push && (!full || pop) && !flush;
  assign rd_en = pop && !empty && !flush;
  assign dout  = mem[rd_ptr];

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_en) rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(wr_en) - CW'(rd_en);
    end
  end

  always_ff @(posedge CLOCK) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC, in-order imem requests, wrong-path squash, fetch buffer to IF/ID.
// Optional halt-word support is compiled in with `define FETCH_HALT_EN.
module if_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter int          BUF_DEPTH = 2
) (
  input  logic             CLOCK,
  input  logic             RESET,
  if_fetch_unit_if.master  imem,
  input  logic             redirect,
  input  logic [31:0]      redirect_pc,
  input  logic             stall,
  output logic             fetch_valid,
  output logic [31:0]      ins,
  output logic [31:0]      PCPlus4F,
  output logic             halted
);

  localparam int CW = $clog2(BUF_DEPTH + 1);

  logic [31:0]   pc_q;
  logic [CW-1:0] inflight_q;
  logic [CW-1:0] drop_q;
  logic [CW-1:0] inflight_nxt;
  logic [CW-1:0] count;
  logic [CW:0]   occupancy;
  logic          fetching;
  logic          gnt_fire;
  logic          rsp_drop;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  fetch_entry_t  push_ent;
  fetch_entry_t  head;

  // Every word in flight already owns a buffer slot, so the buffer can never overflow.
  assign occupancy      = {1'b0, inflight_q} + {1'b0, count};
  assign imem.imem_req  = !RESET && fetching && !full && (occupancy < (CW+1)'(BUF_DEPTH));
  assign imem.imem_addr = pc_q;

  assign gnt_fire     = imem.imem_req && imem.imem_gnt;
  assign rsp_drop     = imem.imem_rvalid && (drop_q != '0);
  assign push         = imem.imem_rvalid && !rsp_drop && fetching && !redirect;
  assign pop          = fetch_valid && !stall && !redirect;
  assign inflight_nxt = inflight_q + CW'(gnt_fire) - CW'(imem.imem_rvalid);

  // Surviving requests are the youngest (inflight - drop) ones, ending just below pc_q.
  assign push_ent.addr = pc_q - {{(30-CW){1'b0}}, inflight_q - drop_q, 2'b00};
  assign push_ent.data = imem.imem_rdata;

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      pc_q       <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
    end else begin
      inflight_q <= inflight_nxt;
      if (redirect) begin
        pc_q   <= redirect_pc;
        drop_q <= inflight_nxt;
      end else begin
        if (gnt_fire) pc_q   <= pc_q + 32'd4;
        if (rsp_drop) drop_q <= drop_q - CW'(1);
      end
    end
  end

  fetch_fifo #(.BUF_DEPTH(BUF_DEPTH)) u_fifo (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .flush (redirect),
    .push  (push),
    .din   (push_ent),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign fetch_valid = !empty;
  assign ins         = fetch_valid ? head.data : NOP_WORD;
  assign PCPlus4F    = fetch_valid ? head.addr + 32'd4 : 32'h0;

`ifdef FETCH_HALT_EN
  logic [0:0] state_q;
  logic       halted_q;

  // The halt word is the last word ever pushed while halted, so popping it ends the stream.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q  <= ST_FETCH;
      halted_q <= 1'b0;
    end else if (redirect) begin
      state_q  <= ST_FETCH;
      halted_q <= 1'b0;
    end else begin
      if (push && imem.imem_rdata == HALT_WORD) state_q <= ST_HALT;
      if (pop && state_q == ST_HALT && head.data == HALT_WORD) halted_q <= 1'b1;
    end
  end

  assign fetching = (state_q == ST_FETCH);
  assign halted   = halted_q;
`else
  assign fetching = 1'b1;
  assign halted   = 1'b0;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: random imem/stall/redirect traffic against a
// queue-based reference model, plus directed scenarios (wrap, squash, stall, halt).
module tb_if_fetch_unit;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam int          BUF_DEPTH = 2;
`ifdef FETCH_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif
  localparam logic [31:0] HALT_W = 32'hFFFF_FFFF;

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        fetch_valid;
  logic [31:0] ins;
  logic [31:0] PCPlus4F;
  logic        halted;

  if_fetch_unit_if bus();

  if_fetch_unit #(.RESET_PC(RESET_PC), .BUF_DEPTH(BUF_DEPTH)) dut (
    .CLOCK       (CLOCK),
    .RESET       (RESET),
    .imem        (bus),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stall       (stall),
    .fetch_valid (fetch_valid),
    .ins         (ins),
    .PCPlus4F    (PCPlus4F),
    .halted      (halted)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct { logic [31:0] addr; bit wrong; int age; } req_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; } word_t;

  req_t        m_out[$];   // requests granted and not yet answered, oldest first
  word_t       m_buf[$];   // words waiting for IF/ID, oldest first
  logic [31:0] m_pc;
  bit          m_haltst;
  bit          m_halted;

  int  n_checks = 0;
  int  n_fail   = 0;
  int  p_gnt, p_rsp, p_stall, p_redir;
  bit  halt_on;
  logic [31:0] halt_addr;
  bit  chk_on = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (halt_on && a == halt_addr) return HALT_W;
    return {a[31:2], 2'b01} ^ 32'h5A3C_0000;
  endfunction

  function automatic bit exp_req();
    return !RESET && !m_haltst && ((m_out.size() + m_buf.size()) < BUF_DEPTH);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_out.delete();
    m_buf.delete();
    m_pc     = RESET_PC;
    m_haltst = 1'b0;
    m_halted = 1'b0;
  endtask

  task automatic model_step();
    bit    fire;
    bit    pop_ok;
    req_t  o;
    word_t w;
    fire   = exp_req() && bus.imem_gnt;
    pop_ok = (m_buf.size() > 0) && !stall && !redirect;
    foreach (m_out[i]) m_out[i].age = m_out[i].age + 1;
    if (pop_ok) begin
      w = m_buf.pop_front();
      if (HALT_EN && w.data == HALT_W) m_halted = 1'b1;
    end
    if (bus.imem_rvalid && m_out.size() > 0) begin
      o = m_out.pop_front();
      if (!o.wrong && !m_haltst && !redirect) begin
        m_buf.push_back('{addr: o.addr, data: bus.imem_rdata});
        if (HALT_EN && bus.imem_rdata == HALT_W) m_haltst = 1'b1;
      end
    end
    if (fire) begin
      m_out.push_back('{addr: m_pc, wrong: 1'b0, age: 0});
      m_pc = m_pc + 32'd4;
    end
    if (redirect) begin
      foreach (m_out[i]) m_out[i].wrong = 1'b1;
      m_buf.delete();
      m_pc     = redirect_pc;
      m_haltst = 1'b0;
      m_halted = 1'b0;
    end
  endtask

  task automatic drive();
    bus.imem_gnt    = (int'($urandom_range(99)) < p_gnt);
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = $urandom;
    if (m_out.size() > 0 && m_out[0].age >= 1 && int'($urandom_range(99)) < p_rsp) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = mem_word(m_out[0].addr);
    end
    stall       = (int'($urandom_range(99)) < p_stall);
    redirect    = (int'($urandom_range(99)) < p_redir);
    redirect_pc = ($urandom_range(1) == 0) ? ($urandom & 32'hFFFF_FFFC)
                                           : (32'hFFFF_FFF0 + ($urandom_range(7) << 2));
  endtask

  task automatic cycle();
    @(posedge CLOCK);
    if (!RESET) model_step();
    #1;
    drive();
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    model_reset();
    cycle();
    cycle();
    RESET = 1'b0;
  endtask

  task automatic next_valid(input string tag, output logic [31:0] pc4, output logic [31:0] iw);
    pc4 = 32'hxxxx_xxxx;
    iw  = 32'hxxxx_xxxx;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (fetch_valid === 1'b1) begin
        pc4 = PCPlus4F;
        iw  = ins;
        return;
      end
    end
    n_checks++;
    n_fail++;
    $display("FAIL %s: no valid word within 40 cycles", tag);
  endtask

  // Every cycle: DUT outputs against the reference model.
  always @(negedge CLOCK) begin
    if (chk_on) begin
      check("imem_req",    {31'b0, bus.imem_req}, {31'b0, exp_req()});
      check("imem_addr",   bus.imem_addr, m_pc);
      check("fetch_valid", {31'b0, fetch_valid}, {31'b0, (m_buf.size() > 0)});
      check("ins",         ins, (m_buf.size() > 0) ? m_buf[0].data : 32'h0);
      check("PCPlus4F",    PCPlus4F, (m_buf.size() > 0) ? m_buf[0].addr + 32'd4 : 32'h0);
      check("halted",      {31'b0, halted}, {31'b0, m_halted});
    end
  end

  initial begin
    logic [31:0] pc4, iw;
    bit saw;
    RESET = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'h0;
    halt_on = 1'b0; halt_addr = 32'h0;
    p_gnt = 0; p_rsp = 0; p_stall = 0; p_redir = 0;
    model_reset();
    cycle();
    chk_on = 1'b1;
    check("rst_req",   {31'b0, bus.imem_req}, 32'h0);
    check("rst_addr",  bus.imem_addr, RESET_PC);
    check("rst_valid", {31'b0, fetch_valid}, 32'h0);
    check("rst_ins",   ins, 32'h0);
    check("rst_pc4",   PCPlus4F, 32'h0);
    check("rst_halt",  {31'b0, halted}, 32'h0);
    cycle();

    // 1: sequential fetch with 1-cycle memory
    p_gnt = 100; p_rsp = 100; p_stall = 0; p_redir = 0;
    drive();
    RESET = 1'b0;
    next_valid("t1_w0", pc4, iw);
    check("t1_pc4_0", pc4, 32'h4);
    check("t1_ins_0", iw, 32'h5A3C_0001);
    next_valid("t1_w1", pc4, iw);
    check("t1_pc4_1", pc4, 32'h8);
    next_valid("t1_w2", pc4, iw);
    check("t1_pc4_2", pc4, 32'hC);

    // 2: long stall fills the buffer and stops requests
    p_stall = 100;
    drive();
    repeat (8) cycle();
    check("t2_req_off", {31'b0, bus.imem_req}, 32'h0);
    check("t2_valid",   {31'b0, fetch_valid}, 32'h1);
    p_stall = 0;
    drive();
    repeat (10) cycle();

    // 3: redirect with two words in flight
    p_rsp = 0;
    drive();
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (m_out.size() == 2 && m_buf.size() == 0) break;
    end
    check("t3_req_full", {31'b0, bus.imem_req}, 32'h0);
    redirect = 1'b1; redirect_pc = 32'h0000_0100;
    cycle();
    p_rsp = 100;
    drive();
    next_valid("t3_w0", pc4, iw);
    check("t3_pc4", pc4, 32'h104);
    check("t3_ins", iw, 32'h5A3C_0101);

    // 4: redirect coincident with a grant and a response
    p_gnt = 0; p_rsp = 100;
    drive();
    repeat (6) cycle();
    cycle();
    bus.imem_gnt = 1'b1;
    cycle();
    cycle();
    check("t4_req", {31'b0, bus.imem_req}, 32'h1);
    if (m_out.size() == 1) begin
      bus.imem_gnt    = 1'b1;
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = mem_word(m_out[0].addr);
      redirect        = 1'b1;
      redirect_pc     = 32'h0000_0200;
    end else begin
      n_checks++; n_fail++;
      $display("FAIL t4_setup: outstanding %0d expected 1", m_out.size());
    end
    cycle();
    p_gnt = 100;
    drive();
    next_valid("t4_w0", pc4, iw);
    check("t4_pc4", pc4, 32'h204);
    check("t4_ins", iw, 32'h5A3C_0201);

    // 5: address wrap
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    next_valid("t5_w0", pc4, iw);
    check("t5_pc4_0", pc4, 32'hFFFF_FFFC);
    check("t5_ins_0", iw, 32'hA5C3_FFF9);
    next_valid("t5_w1", pc4, iw);
    check("t5_pc4_1", pc4, 32'h0000_0000);
    check("t5_ins_1", iw, 32'hA5C3_FFFD);
    next_valid("t5_w2", pc4, iw);
    check("t5_pc4_2", pc4, 32'h0000_0004);

    // random traffic, with a reset landing mid-transfer
    p_gnt = 70; p_rsp = 60; p_stall = 30; p_redir = 3;
    drive();
    repeat (1500) cycle();
    do_reset();
    p_gnt = 90; p_rsp = 80; p_stall = 50; p_redir = 2;
    drive();
    repeat (1500) cycle();

`ifdef FETCH_HALT_EN
    // 6: halt word at address 8
    p_gnt = 100; p_rsp = 100; p_stall = 0; p_redir = 0;
    halt_on = 1'b1; halt_addr = 32'h8;
    do_reset();
    saw = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (fetch_valid === 1'b1 && ins === HALT_W) begin
        saw = 1'b1;
        check("t6_halt_pc4", PCPlus4F, 32'hC);
      end
      if (halted === 1'b1) break;
    end
    check("t6_delivered", {31'b0, saw}, 32'h1);
    check("t6_halted",    {31'b0, halted}, 32'h1);
    repeat (5) cycle();
    check("t6_req_off",   {31'b0, bus.imem_req}, 32'h0);
    halt_on = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h0;
    cycle();
    check("t6_resume",    {31'b0, halted}, 32'h0);
    next_valid("t6_w0", pc4, iw);
    check("t6_pc4", pc4, 32'h4);
`else
    saw = 1'b0;
`endif

    chk_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
